// File: rtl/cfu_issue.sv
// cfu_issue: CPU-side initiator for the custom function unit port.
// Takes one op from execute, drives the CFU request bus until the CFU stops
// stalling (or a stall timeout expires), then holds the result for writeback.
// Ops never overlap: a new op is only accepted once the previous result has
// been consumed, so throughput is at most one op every three cycles.
module cfu_issue #(
  parameter int TIMEOUT = 256,
  parameter int TAG_W   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [6:0]       req_funct7_i,
  input  logic [31:0]      req_src1_i,
  input  logic [31:0]      req_src2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_rslt_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             cfu_en_o,
  output logic [2:0]       cfu_funct3_o,
  output logic [6:0]       cfu_funct7_o,
  output logic [31:0]      cfu_src1_o,
  output logic [31:0]      cfu_src2_o,
  input  logic             cfu_stall_i,
  input  logic [31:0]      cfu_rslt_i,
  output logic             busy_o,
  output logic [31:0]      op_count_o
);

  // Stall counter is just wide enough to reach TIMEOUT; one bit when the
  // timeout is disabled, where it simply saturates.
  localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TO_LIM  = (CNT_W + 1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t             state_reg;
  logic               req_ready_reg;
  logic               busy_reg;
  logic               cfu_en_reg;
  logic [2:0]         funct3_reg;
  logic [6:0]         funct7_reg;
  logic [31:0]        src1_reg;
  logic [31:0]        src2_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic               rsp_valid_reg;
  logic [31:0]        rslt_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic [31:0]        op_count_reg;
  logic               timeout_hit;

  // This stalled edge is the one that brings the stall count up to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && cfu_stall_i &&
                       (({1'b0, stall_cnt_reg} + 1'b1) == TO_LIM);

  // Single-process FSM; every output is a register so reset clears them
  // asynchronously (cfu_en_o drops the moment rst_i rises).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      req_ready_reg <= 1'b1;
      busy_reg      <= 1'b0;
      cfu_en_reg    <= 1'b0;
      funct3_reg    <= '0;
      funct7_reg    <= '0;
      src1_reg      <= '0;
      src2_reg      <= '0;
      tag_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rslt_reg      <= '0;
      err_reg       <= 1'b0;
      stall_cnt_reg <= '0;
      op_count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            funct3_reg    <= req_funct3_i;
            funct7_reg    <= req_funct7_i;
            src1_reg      <= req_src1_i;
            src2_reg      <= req_src2_i;
            tag_reg       <= req_tag_i;
            stall_cnt_reg <= '0;
            cfu_en_reg    <= 1'b1;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!cfu_stall_i || timeout_hit) begin
            // Result from the CFU, or a zero result flagged as an abort.
            rslt_reg      <= cfu_stall_i ? 32'd0 : cfu_rslt_i;
            err_reg       <= cfu_stall_i;
            cfu_en_reg    <= 1'b0;
            funct3_reg    <= '0;
            funct7_reg    <= '0;
            src1_reg      <= '0;
            src2_reg      <= '0;
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else if (stall_cnt_reg != CNT_MAX) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
            op_count_reg  <= op_count_reg + 32'd1;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_reg;
  assign busy_o       = busy_reg;
  assign cfu_en_o     = cfu_en_reg;
  assign cfu_funct3_o = funct3_reg;
  assign cfu_funct7_o = funct7_reg;
  assign cfu_src1_o   = src1_reg;
  assign cfu_src2_o   = src2_reg;
  assign rsp_valid_o  = rsp_valid_reg;
  assign rsp_rslt_o   = rslt_reg;
  assign rsp_tag_o    = tag_reg;
  assign rsp_err_o    = err_reg;
  assign op_count_o   = op_count_reg;

endmodule
